// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, with a shift-enable strobe.
// Supports back-to-back words and a downstream stall.
module serializer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          stall,
    output logic          out_en,
    output logic          out_bit,
    output logic          out_last,
    output logic          busy
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc;
    logic            at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        at_last  = (state_q == SHIFT) && (cnt_q == LAST);
        // a new word may land on the same edge the last bit leaves
        in_ready = (state_q == IDLE) || (at_last && !stall);
        acc      = in_valid && in_ready;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!stall) begin
                    if (cnt_q != LAST) begin
                        sreg_d = {sreg_q[DW-2:0], 1'b0};
                        cnt_d  = cnt_q + 1'b1;
                    end else if (acc) begin
                        sreg_d = in_data;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign out_en   = busy && !stall;
    assign out_bit  = out_en && sreg_q[DW-1];
    assign out_last = out_en && (cnt_q == LAST);

endmodule
